// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants, traffic-generator modes, states and LFSR seed
package fifo_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_BURST      = 2'b00,
        MODE_CONCURRENT = 2'b01,
        MODE_FILL       = 2'b10,
        MODE_RANDOM     = 2'b11
    } mode_e;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FRST  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_MIXED = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit maximal-length Fibonacci LFSR (x^16+x^14+x^13+x^11+1)
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [1:0]  rnd
);

    logic [15:0] q;
    logic        fb;

    assign fb  = q[15] ^ q[13] ^ q[12] ^ q[10];
    assign rnd = q[1:0];

    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= seed;
        end else begin
            q <= {q[14:0], fb};
        end
    end

endmodule

// File: rtl/fifo_traffic_gen.sv
// rtl/fifo_traffic_gen.sv - FIFO traffic generator/checker; TRAFFIC_GEN_LFSR_EN enables random gating
module fifo_traffic_gen #(
    parameter int DATA_WIDTH  = fifo_pkg::DATA_WIDTH,
    parameter int COUNT_WIDTH = 16,
    parameter int RST_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [COUNT_WIDTH-1:0] num_xfers,
    output logic                   fifo_rst_n,
    output logic                   wr_en,
    output logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   full,
    output logic                   rd_en,
    input  logic [DATA_WIDTH-1:0]  data_out,
    input  logic                   empty,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] wr_count,
    output logic [COUNT_WIDTH-1:0] rd_count,
    output logic                   mismatch,
    output logic [COUNT_WIDTH-1:0] err_count
);
    import fifo_pkg::*;

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    logic [2:0]             state;
    logic [1:0]             mode_q;
    logic [COUNT_WIDTH-1:0] num_q;
    logic [RW-1:0]          rst_cnt;
    logic                   rd_pend;
    logic [DATA_WIDTH-1:0]  exp_q;
    logic                   wr_gate;
    logic                   rd_gate;
    logic                   bad;

`ifdef TRAFFIC_GEN_LFSR_EN
    logic [1:0] rnd;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (state == ST_IDLE && start),
        .seed (LFSR_SEED),
        .rnd  (rnd)
    );

    assign wr_gate = (mode_q != MODE_RANDOM) || rnd[0];
    assign rd_gate = (mode_q != MODE_RANDOM) || rnd[1];
`else
    assign wr_gate = 1'b1;
    assign rd_gate = 1'b1;
`endif

    // Outputs are forced inactive combinationally so rst takes effect before the first edge.
    assign wr_en = !rst && (state == ST_WRITE || state == ST_MIXED) && !full
                   && (wr_count < num_q) && wr_gate;
    assign rd_en = !rst && (state == ST_READ || state == ST_MIXED) && !empty
                   && (rd_count < wr_count) && rd_gate;
    assign data_in    = wr_count[DATA_WIDTH-1:0];
    assign busy       = !rst && (state != ST_IDLE);
    assign done       = !rst && (state == ST_DONE);
    assign fifo_rst_n = !rst && (state != ST_FRST);
    assign bad        = rd_pend && (data_out != exp_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= 2'b00;
            num_q     <= '0;
            rst_cnt   <= '0;
            wr_count  <= '0;
            rd_count  <= '0;
            rd_pend   <= 1'b0;
            exp_q     <= '0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            // FIFO read data lands one cycle after rd_en; compare it then.
            rd_pend <= rd_en;
            exp_q   <= rd_count[DATA_WIDTH-1:0];
            if (wr_en) wr_count <= wr_count + 1'b1;
            if (rd_en) rd_count <= rd_count + 1'b1;
            if (bad) begin
                mismatch <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        num_q     <= num_xfers;
                        wr_count  <= '0;
                        rd_count  <= '0;
                        mismatch  <= 1'b0;
                        err_count <= '0;
                        rst_cnt   <= '0;
                        rd_pend   <= 1'b0;
                        state     <= ST_FRST;
                    end
                end
                ST_FRST: begin
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        if (num_q == '0)
                            state <= ST_DONE;
                        else if (mode_q == MODE_BURST || mode_q == MODE_FILL)
                            state <= ST_WRITE;
                        else
                            state <= ST_MIXED;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (wr_count == num_q || full)
                        state <= (mode_q == MODE_FILL) ? ST_DONE : ST_READ;
                end
                ST_READ: begin
                    if (rd_count == num_q)
                        state <= ST_DONE;
                    else if (rd_count == wr_count && wr_count < num_q)
                        state <= ST_WRITE;
                end
                ST_MIXED: begin
                    if (rd_count == num_q) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_traffic_gen.md
FIFO_TRAFFIC_GEN -- requirements
Module: fifo_traffic_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of FIFO data words.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, width of transfer counters.
REQ-003 SHALL have parameter RST_CYCLES, default 4, number of cycles the FIFO reset is held low.
REQ-004 SHALL have these ports:
  clk  in  1  single clock; all logic on its rising edge.
  rst  in  1  synchronous, active-high reset.
  start  in  1  one-cycle run request.
  mode  in  2  00 BURST, 01 CONCURRENT, 10 FILL, 11 RANDOM.
  num_xfers  in  COUNT_WIDTH  words to transfer per run.
  fifo_rst_n  out  1  active-low reset to the FIFO under test.
  wr_en  out  1  FIFO write enable.
  data_in  out  DATA_WIDTH  write data.
  full  in  1  FIFO full flag.
  rd_en  out  1  FIFO read enable.
  data_out  in  DATA_WIDTH  FIFO read data.
  empty  in  1  FIFO empty flag.
  busy  out  1  run in progress.
  done  out  1  one-cycle end-of-run pulse.
  wr_count  out  COUNT_WIDTH  words written this run.
  rd_count  out  COUNT_WIDTH  words read this run.
  mismatch  out  1  sticky read-data error.
  err_count  out  COUNT_WIDTH  saturating read-data error count.

Function
REQ-005 SHALL implement the states IDLE, FRST, WRITE, READ, MIXED and DONE.
REQ-006 IDLE: on start, SHALL latch mode and num_xfers, clear the counters, mismatch and err_count, and go to FRST; busy=1 in every state except IDLE.
REQ-007 FRST: SHALL drive fifo_rst_n=0 for exactly RST_CYCLES cycles, then go to DONE if num_xfers==0, else to WRITE for BURST/FILL or to MIXED for CONCURRENT/RANDOM.
REQ-008 wr_en SHALL be combinational and equal (state WRITE or MIXED) && !full && wr_count<num_xfers, further gated in RANDOM mode per REQ-020.
REQ-009 data_in SHALL equal wr_count[DATA_WIDTH-1:0], wrapping modulo 2^DATA_WIDTH.
REQ-010 rd_en SHALL be combinational and equal (state READ or MIXED) && !empty && rd_count<wr_count, further gated in RANDOM mode per REQ-020.
REQ-011 wr_count and rd_count SHALL each increment by 1 in every cycle in which wr_en or rd_en, respectively, is asserted.
REQ-012 BURST: WRITE SHALL go to READ when wr_count reaches num_xfers or when full is sampled high; READ SHALL go to WRITE when rd_count==wr_count<num_xfers, and to DONE when rd_count==num_xfers.
REQ-013 FILL: WRITE SHALL go to DONE when wr_count==num_xfers or full is sampled high, and SHALL never assert rd_en.
REQ-014 MIXED SHALL allow a simultaneous write and read in the same cycle and SHALL go to DONE when rd_count==num_xfers.
REQ-015 Read data SHALL be sampled one cycle after rd_en and compared with a registered expected value equal to rd_count[DATA_WIDTH-1:0] at the time of the read.
REQ-016 On a data compare failure, mismatch SHALL be set and held until the next start or rst, and err_count SHALL increment, saturating at its all-ones value.
REQ-017 DONE SHALL last one cycle, assert done=1, and return to IDLE.
REQ-018 start SHALL be ignored whenever the block is not in IDLE.

Reset
REQ-019 While rst=1: state=IDLE, fifo_rst_n=0, wr_en=0, rd_en=0, busy=0, done=0, all counters=0, mismatch=0; after rst deasserts, fifo_rst_n=1 in IDLE; rst mid-run SHALL abort the run with no done pulse.

Configuration
REQ-020 With TRAFFIC_GEN_LFSR_EN defined, SHALL include a 16-bit maximal-length LFSR, seeded 16'hACE1 on rst and on start and advancing every cycle, and in RANDOM mode SHALL additionally gate wr_en with LFSR bit 0 and rd_en with LFSR bit 1.
REQ-021 Without TRAFFIC_GEN_LFSR_EN, RANDOM mode SHALL behave identically to CONCURRENT and no LFSR logic SHALL exist.

Structure
REQ-022 The mode and state enumerations and the LFSR seed constant SHALL reside in the shared package fifo_pkg, alongside the existing DATA_WIDTH constant.
REQ-023 The LFSR SHALL be a separate sub-module named lfsr16, instantiated only under TRAFFIC_GEN_LFSR_EN.

Verification
REQ-024 BURST, num_xfers=20, depth-8 FIFO -> write/read bursts of 8,8,4, done after rd_count=20, mismatch=0.
REQ-025 FILL, num_xfers=100, depth 8 -> wr_count=8, rd_en never asserted, done pulse.
REQ-026 CONCURRENT, num_xfers=300, DATA_WIDTH=8 -> data_in wraps 255->0, rd_count=300, err_count=0.
REQ-027 Corrupt data_out on the 5th read -> mismatch=1, err_count=1, run still completes.
REQ-028 rst asserted 3 cycles into WRITE -> next cycle IDLE, fifo_rst_n=0, no done; start with num_xfers=0 -> FRST for 4 cycles, then DONE.
REQ-029 RANDOM with and without TRAFFIC_GEN_LFSR_EN, num_xfers=50 -> both complete with rd_count=50 and mismatch=0.
